hsv_pipe_arbiter: RTL and testbench

Round-robin scheduler that shares one fully pipelined `rgb2hsv` converter between two pixel requesters. It tracks requester tags through the converter's fixed latency and steers results into per-requester output FIFOs. Credit-based flow control ensures no result is ever dropped. It sits between the two camera/pixel sources and the HSV consumers (colour-threshold blocks).

---
 rtl/hsv_pipe_arbiter.sv | 142 ++++++++++++++
 tb/tb_hsv_pipe_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_pipe_arbiter.sv
// rtl/hsv_pipe_arbiter.sv - round-robin sharing of one pipelined rgb2hsv between two requesters
// Tags follow each pixel through the converter; credits bound in-flight plus buffered results per FIFO.
module hsv_pipe_arbiter #(
  parameter int LATENCY    = 22,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [23:0] req0_rgb,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [23:0] req1_rgb,
  output logic        req1_ready,
  output logic [7:0]  pipe_r,
  output logic [7:0]  pipe_g,
  output logic [7:0]  pipe_b,
  input  logic [7:0]  pipe_h,
  input  logic [7:0]  pipe_s,
  input  logic [7:0]  pipe_v,
  output logic        out0_valid,
  output logic [23:0] out0_hsv,
  input  logic        out0_ready,
  output logic        out1_valid,
  output logic [23:0] out1_hsv,
  input  logic        out1_ready,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [1:0][CW-1:0] credit_q, credit_d;
  logic [1:0][CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0][CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [23:0]        mem_q [2][FIFO_DEPTH];
  logic [23:0]        mem_d [2][FIFO_DEPTH];
  logic               last_grant_q, last_grant_d;
  logic [23:0]        pipe_rgb_q, pipe_rgb_d;
  logic               issue_vld_q, issue_vld_d;
  logic               issue_id_q, issue_id_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [LATENCY-1:0] tag_id_q, tag_id_d;

  logic [1:0] elig, accept, pop, wr_en, empty, full;
  logic [1:0] out_ready;
  logic       ret_vld, ret_id;

  assign out_ready = {out1_ready, out0_ready};
  assign ret_vld   = tag_vld_q[LATENCY-1];
  assign ret_id    = tag_id_q[LATENCY-1];

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      elig[n]  = credit_q[n] < CW'(FIFO_DEPTH);
      empty[n] = wr_ptr_q[n] == rd_ptr_q[n];
      full[n]  = (wr_ptr_q[n][AW] != rd_ptr_q[n][AW]) &&
                 (wr_ptr_q[n][AW-1:0] == rd_ptr_q[n][AW-1:0]);
    end
    // A tie goes to whichever requester was not granted last.
    req0_ready = !reset && elig[0] && (!(req1_valid && elig[1]) || last_grant_q);
    req1_ready = !reset && elig[1] && (!(req0_valid && elig[0]) || !last_grant_q);
    accept     = {req1_valid && req1_ready, req0_valid && req0_ready};
    out0_valid = !reset && !empty[0];
    out1_valid = !reset && !empty[1];
    pop        = {out1_valid && out1_ready, out0_valid && out0_ready};
    wr_en      = {ret_vld && ret_id, ret_vld && !ret_id};
    out0_hsv   = empty[0] ? 24'd0 : mem_q[0][rd_ptr_q[0][AW-1:0]];
    out1_hsv   = empty[1] ? 24'd0 : mem_q[1][rd_ptr_q[1][AW-1:0]];
    busy       = !reset && (credit_q != '0);
  end

  always_comb begin
    credit_d     = credit_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;
    last_grant_d = last_grant_q;
    for (int n = 0; n < 2; n++) begin
      if (accept[n] && !pop[n]) begin
        credit_d[n] = credit_q[n] + CW'(1);
      end else if (!accept[n] && pop[n]) begin
        credit_d[n] = credit_q[n] - CW'(1);
      end
      if (wr_en[n]) begin
        mem_d[n][wr_ptr_q[n][AW-1:0]] = {pipe_h, pipe_s, pipe_v};
        wr_ptr_d[n] = wr_ptr_q[n] + CW'(1);
      end
      if (pop[n]) begin
        rd_ptr_d[n] = rd_ptr_q[n] + CW'(1);
      end
    end
    if (accept[1]) begin
      last_grant_d = 1'b1;
    end else if (accept[0]) begin
      last_grant_d = 1'b0;
    end
    pipe_rgb_d  = accept[0] ? req0_rgb : (accept[1] ? req1_rgb : 24'd0);
    issue_vld_d = |accept;
    issue_id_d  = accept[1];
    // The issue register lines up with pipe_rgb; the shift chain covers the converter latency.
    tag_vld_d   = {tag_vld_q[LATENCY-2:0], issue_vld_q};
    tag_id_d    = {tag_id_q[LATENCY-2:0], issue_id_q};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      credit_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_grant_q <= 1'b1;
      pipe_rgb_q   <= '0;
      issue_vld_q  <= 1'b0;
      issue_id_q   <= 1'b0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
    end else begin
      credit_q     <= credit_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      last_grant_q <= last_grant_d;
      pipe_rgb_q   <= pipe_rgb_d;
      issue_vld_q  <= issue_vld_d;
      issue_id_q   <= issue_id_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign pipe_r = pipe_rgb_q[23:16];
  assign pipe_g = pipe_rgb_q[15:8];
  assign pipe_b = pipe_rgb_q[7:0];

  for (genvar n = 0; n < 2; n++) begin : g_chk
    a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(wr_en[n] && full[n]));
  end

endmodule

// File: tb/tb_hsv_pipe_arbiter.sv
// tb/tb_hsv_pipe_arbiter.sv - scoreboard bench for hsv_pipe_arbiter with a behavioural converter
module tb_hsv_pipe_arbiter;

  localparam int LAT   = 22;
  localparam int DEPTH = 32;
  localparam int PER   = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [23:0] req0_rgb, req1_rgb;
  logic [7:0]  pipe_r, pipe_g, pipe_b, pipe_h, pipe_s, pipe_v;
  logic        out0_valid, out1_valid, out0_ready, out1_ready, busy;
  logic [23:0] out0_hsv, out1_hsv;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] src0_rgb[$], src0_exp[$], src1_rgb[$], src1_exp[$];
  logic [23:0] exp0[$], exp1[$];
  int          grant_log[$];
  time         acc1_t[$];
  time         acc0_time = 0;
  int          acc_cnt0 = 0;

  always #(PER/2) clock = ~clock;

  hsv_pipe_arbiter #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_rgb(req0_rgb), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rgb(req1_rgb), .req1_ready(req1_ready),
    .pipe_r(pipe_r), .pipe_g(pipe_g), .pipe_b(pipe_b),
    .pipe_h(pipe_h), .pipe_s(pipe_s), .pipe_v(pipe_v),
    .out0_valid(out0_valid), .out0_hsv(out0_hsv), .out0_ready(out0_ready),
    .out1_valid(out1_valid), .out1_hsv(out1_hsv), .out1_ready(out1_ready),
    .busy(busy)
  );

  function automatic logic [23:0] rgb2hsv(input logic [23:0] rgb);
    int r, g, b, mx, mn, d, h, s;
    r  = int'(rgb[23:16]);
    g  = int'(rgb[15:8]);
    b  = int'(rgb[7:0]);
    mx = (r > g) ? ((r > b) ? r : b) : ((g > b) ? g : b);
    mn = (r < g) ? ((r < b) ? r : b) : ((g < b) ? g : b);
    d  = mx - mn;
    s  = (mx == 0) ? 0 : (255 * d) / mx;
    if (d == 0)       h = 0;
    else if (mx == r) h = (43 * (g - b)) / d;
    else if (mx == g) h = 85 + (43 * (b - r)) / d;
    else              h = 170 + (43 * (r - g)) / d;
    if (h < 0) h = h + 256;
    return {8'(h), 8'(s), 8'(mx)};
  endfunction

  logic [23:0] conv_q [LAT] = '{default: 24'd0};
  always @(posedge clock) begin
    conv_q[0] <= {pipe_r, pipe_g, pipe_b};
    for (int i = 1; i < LAT; i++) conv_q[i] <= conv_q[i-1];
  end
  assign {pipe_h, pipe_s, pipe_v} = rgb2hsv(conv_q[LAT-1]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Driver: pushes the expected result onto the scoreboard at the accepting edge.
  initial begin
    logic a0, a1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_rgb = '0; req1_rgb = '0;
    forever begin
      @(negedge clock);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clock);
      if (a0) begin
        exp0.push_back(src0_exp.pop_front());
        void'(src0_rgb.pop_front());
        acc_cnt0++;
        acc0_time = $time;
        grant_log.push_back(0);
      end
      if (a1) begin
        exp1.push_back(src1_exp.pop_front());
        void'(src1_rgb.pop_front());
        acc1_t.push_back($time);
        grant_log.push_back(1);
      end
      #1;
      req0_valid = src0_rgb.size() > 0;
      req0_rgb   = req0_valid ? src0_rgb[0] : 24'd0;
      req1_valid = src1_rgb.size() > 0;
      req1_rgb   = req1_valid ? src1_rgb[0] : 24'd0;
    end
  end

  // Monitor: compares every popped FIFO head with the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (out0_valid && out0_ready) begin
        if (exp0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL out0_unexpected: got %0h, required no output", out0_hsv);
        end else check("out0_hsv", 32'(out0_hsv), 32'(exp0.pop_front()));
      end
      if (out1_valid && out1_ready) begin
        if (exp1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL out1_unexpected: got %0h, required no output", out1_hsv);
        end else check("out1_hsv", 32'(out1_hsv), 32'(exp1.pop_front()));
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1'b1;
    src0_rgb.delete(); src0_exp.delete(); src1_rgb.delete(); src1_exp.delete();
    exp0.delete(); exp1.delete();
    @(posedge clock); #2;
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (src0_rgb.size() == 0 && src1_rgb.size() == 0 && exp0.size() == 0 &&
          exp1.size() == 0 && !busy) break;
    end
    if (i == max_cyc) check(name, 32'd1, 32'd0);
  endtask

  task automatic check_latency(input string name);
    int i;
    for (i = 0; i < 60 && !out0_valid; i++) @(negedge clock);
    if (!out0_valid) check(name, 32'd0, 32'd1);
    else check(name, 32'(int'(($time - PER/2 - acc0_time) / PER)), 32'(LAT + 1));
  endtask

  initial begin
    logic seen;
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    check("rst_valid", 32'({out0_valid, out1_valid}), 32'd0);
    check("rst_hsv", 32'(out0_hsv | out1_hsv), 32'd0);
    check("rst_pipe", 32'({pipe_r, pipe_g, pipe_b}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clock); #2;
    reset = 1'b0;

    // Single red pixel: latency and idle second output.
    repeat (5) @(posedge clock); #2;
    src0_rgb.push_back(24'hFF0000); src0_exp.push_back(24'h00FFFF);
    seen = 1'b0;
    for (int i = 0; i < 60 && !out0_valid; i++) begin
      @(negedge clock);
      if (out1_valid) seen = 1'b1;
    end
    if (!out0_valid) check("t1_latency", 32'd0, 32'd1);
    else check("t1_latency", 32'(int'(($time - PER/2 - acc0_time) / PER)), 32'(LAT + 1));
    wait_idle("t1_idle", 50);
    check("t1_out1_quiet", 32'(seen), 32'd0);

    // Both streaming: grants alternate starting with req0.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 8; i++) begin
      src0_rgb.push_back(24'h00FF00); src0_exp.push_back(24'h55FFFF);
      src1_rgb.push_back(24'h0000FF); src1_exp.push_back(24'hAAFFFF);
    end
    wait_idle("t2_idle", 100);
    check("t2_grants", 32'(grant_log.size()), 32'd16);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) check("t2_order", 32'(grant_log[i]), 32'(i % 2));

    // Backpressure on output 0.
    do_reset();
    out0_ready = 1'b0; acc_cnt0 = 0; acc1_t.delete();
    for (int i = 1; i <= 40; i++) begin
      src0_rgb.push_back({8'(i), 8'(i), 8'(i)}); src0_exp.push_back({16'h0000, 8'(i)});
    end
    for (int i = 1; i <= 60; i++) begin
      src1_rgb.push_back({8'(i), 16'h0000}); src1_exp.push_back({16'h00FF, 8'(i)});
    end
    repeat (120) @(negedge clock);
    check("t3_acc0", 32'(acc_cnt0), 32'd32);
    check("t3_ready0_low", 32'(req0_ready), 32'd0);
    check("t3_acc1", 32'(acc1_t.size()), 32'd60);
    if (acc1_t.size() == 60) check("t3_req1_rate", 32'(int'((acc1_t[59] - acc1_t[40]) / PER)), 32'd19);
    @(posedge clock); #1;
    out0_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("t3_resume", 32'(req0_ready), 32'd1);
    wait_idle("t3_idle", 200);
    check("t3_acc0_all", 32'(acc_cnt0), 32'd40);

    // Accept and pop on the same edge at credit 31.
    do_reset();
    out0_ready = 1'b0; acc_cnt0 = 0;
    for (int i = 0; i < 31; i++) begin
      src0_rgb.push_back({3{8'(100 + i)}}); src0_exp.push_back({16'h0000, 8'(100 + i)});
    end
    repeat (60) @(negedge clock);
    check("t4_acc31", 32'(acc_cnt0), 32'd31);
    check("t4_ready31", 32'(req0_ready), 32'd1);
    @(posedge clock); #2;
    src0_rgb.push_back({3{8'd200}}); src0_exp.push_back({16'h0000, 8'd200});
    @(posedge clock); #2;
    out0_ready = 1'b1;
    @(posedge clock); #2;
    out0_ready = 1'b0;
    @(negedge clock);
    check("t4_hold_ready", 32'(req0_ready), 32'd1);
    check("t4_acc32", 32'(acc_cnt0), 32'd32);
    src0_rgb.push_back({3{8'd201}}); src0_exp.push_back({16'h0000, 8'd201});
    repeat (3) @(negedge clock);
    check("t4_full_ready", 32'(req0_ready), 32'd0);
    check("t4_acc33", 32'(acc_cnt0), 32'd33);
    @(posedge clock); #1;
    out0_ready = 1'b1;
    wait_idle("t4_idle", 100);

    // Reset mid-stream discards in-flight pixels, then a black pixel.
    do_reset();
    acc_cnt0 = 0;
    for (int i = 0; i < 5; i++) begin
      src0_rgb.push_back({3{8'(50 + i)}}); src0_exp.push_back({16'h0000, 8'(50 + i)});
    end
    for (int i = 0; i < 20 && acc_cnt0 < 5; i++) @(negedge clock);
    check("t5_acc5", 32'(acc_cnt0), 32'd5);
    repeat (10) @(posedge clock);
    do_reset();
    @(negedge clock);
    check("t5_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (out0_valid) seen = 1'b1;
    end
    check("t5_no_out", 32'(seen), 32'd0);
    src0_rgb.push_back(24'h000000); src0_exp.push_back(24'h000000);
    check_latency("t5_latency");
    wait_idle("t5_idle", 50);
    check("sb_empty", 32'(exp0.size() + exp1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
